mixcol_addkey: RTL

Round back-end stage for the AES core. Sits directly downstream of `subbytes`, which performs SubBytes and ShiftRows, or their inverses. Takes the 128-bit substituted state plus the round key and produces the round output (MixColumns + AddRoundKey, or AddRoundKey + InvMixColumns) over one column per cycle, with valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/mixcol_addkey_if.sv | 22 ++
 rtl/mixcol_word.sv | 36 +++
 rtl/mixcol_addkey.sv | 94 +++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) constant multipliers, round-stage FSM states
// and the column index type.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef logic [1:0] col_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul02(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul03(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mixcol_addkey_if.sv
// Upstream/downstream handshake bundle for the mixcol_addkey round stage.
interface mixcol_addkey_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         in_last;
  logic         decrypt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, in_key, in_last, decrypt, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_key, in_last, decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mixcol_word.sv
// One-column (Inv)MixColumns + AddRoundKey; key goes after MixColumns when
// encrypting and before InvMixColumns when decrypting.
module mixcol_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic [31:0] key_i,
  input  logic        decrypt_i,
  input  logic        bypass_i,
  output logic [31:0] col_o
);

  logic [7:0]  s0, s1, s2, s3;
  logic [7:0]  t0, t1, t2, t3;
  logic [31:0] t_w, enc_w, dec_w;

  assign {s0, s1, s2, s3} = col_i;
  assign t_w              = col_i ^ key_i;
  assign {t0, t1, t2, t3} = t_w;

  assign enc_w = {gmul02(s0) ^ gmul03(s1) ^ s2 ^ s3,
                  s0 ^ gmul02(s1) ^ gmul03(s2) ^ s3,
                  s0 ^ s1 ^ gmul02(s2) ^ gmul03(s3),
                  gmul03(s0) ^ s1 ^ s2 ^ gmul02(s3)} ^ key_i;

  assign dec_w = {gmul0e(t0) ^ gmul0b(t1) ^ gmul0d(t2) ^ gmul09(t3),
                  gmul09(t0) ^ gmul0e(t1) ^ gmul0b(t2) ^ gmul0d(t3),
                  gmul0d(t0) ^ gmul09(t1) ^ gmul0e(t2) ^ gmul0b(t3),
                  gmul0b(t0) ^ gmul0d(t1) ^ gmul09(t2) ^ gmul0e(t3)};

  always_comb begin
    col_o = t_w;
    if (!bypass_i) col_o = decrypt_i ? dec_w : enc_w;
  end

endmodule

// File: rtl/mixcol_addkey.sv
// AES round back-end: captures one block, produces one result column per cycle,
// then holds the full result until the downstream takes it.
module mixcol_addkey
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mixcol_addkey_if.slave bus
);

  state_e       state_q, state_d;
  col_t         col_q, col_d;
  logic [127:0] data_q, key_q, out_q;
  logic         last_q, dec_q;
  logic         accept;
  logic [31:0]  s_col, k_col, r_col;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        if (col_q == 2'd3) state_d = DONE;
        else               col_d   = col_q + 2'd1;
      end
      DONE: if (bus.out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) col_d = '0;
  end

  // in_ready is forced low during reset so nothing is accepted on the reset edge
  always_comb begin
    bus.in_ready  = !rst && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
    bus.out_valid = (state_q == DONE);
    bus.out_data  = out_q;
  end

  always_comb begin
    case (col_q)
      2'd0:    begin s_col = data_q[127:96]; k_col = key_q[127:96]; end
      2'd1:    begin s_col = data_q[95:64];  k_col = key_q[95:64];  end
      2'd2:    begin s_col = data_q[63:32];  k_col = key_q[63:32];  end
      default: begin s_col = data_q[31:0];   k_col = key_q[31:0];   end
    endcase
  end

  mixcol_word u_word (
    .col_i     (s_col),
    .key_i     (k_col),
    .decrypt_i (dec_q),
    .bypass_i  (last_q),
    .col_o     (r_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      key_q  <= '0;
      last_q <= 1'b0;
      dec_q  <= 1'b0;
      out_q  <= '0;
    end else begin
      if (accept) begin
        data_q <= bus.in_data;
        key_q  <= bus.in_key;
        last_q <= bus.in_last;
        dec_q  <= bus.decrypt;
      end
      if (state_q == BUSY) begin
        case (col_q)
          2'd0:    out_q[127:96] <= r_col;
          2'd1:    out_q[95:64]  <= r_col;
          2'd2:    out_q[63:32]  <= r_col;
          default: out_q[31:0]   <= r_col;
        endcase
      end
    end
  end

endmodule
